axil_wr_arbiter: RTL and testbench
==================================

// Module: axil_wr_arbiter
// PURPOSE
//  N-master to one-slave-port AXI-Lite write-path arbiter and sequencer for the interconnect.
//  Round-robin grant on AW; the grant is held for one full AW->W->B transaction.
//  Sequences the external address decoder and forwards decoded writes with an m_sel slave id.
//  Unmapped addresses are completed locally with BRESP=DECERR; nothing is forwarded.
// PARAMETERS
//  N          2                   number of masters (>=2)
//  M          4                   number of slaves (width of m_sel / dec_slave_id only)
//  ADDR_WIDTH 32                  address width
//  DATA_WIDTH 32                  data width; strobe width = DATA_WIDTH/8
//  SLAVE_ID_W (M>1)?$clog2(M):1   slave id width
//  GNT_W      $clog2(N)           grant index width
// PORTS
//  clk          in   1              clock; all logic on posedge
//  rst          in   1              synchronous, active-high reset
//  s_awaddr     in   N*ADDR_WIDTH   per-master AW address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  s_awvalid    in   N              per-master AW valid
//  s_awready    out  N              per-master AW ready
//  s_wdata      in   N*DATA_WIDTH   per-master W data
//  s_wstrb      in   N*DATA_WIDTH/8 per-master W strobes
//  s_wvalid     in   N              per-master W valid
//  s_wready     out  N              per-master W ready
//  s_bresp      out  2              B response, shared; meaningful only with s_bvalid[i]
//  s_bvalid     out  N              per-master B valid
//  s_bready     in   N              per-master B ready
//  m_awaddr     out  ADDR_WIDTH     forwarded AW address (= awaddr_q)
//  m_awvalid    out  1              forwarded AW valid
//  m_awready    in   1              forwarded AW ready
//  m_wdata      out  DATA_WIDTH     granted master's s_wdata
//  m_wstrb      out  DATA_WIDTH/8   granted master's s_wstrb
//  m_wvalid     out  1              forwarded W valid
//  m_wready     in   1              forwarded W ready
//  m_bresp      in   2              slave B response
//  m_bvalid     in   1              slave B valid
//  m_bready     out  1              slave B ready
//  m_sel        out  SLAVE_ID_W     registered target slave id for the current transaction
//  dec_addr     out  ADDR_WIDTH     address to the external decoder (= awaddr_q)
//  dec_slave_id in   SLAVE_ID_W     decoder result; combinational from dec_addr
//  dec_decerr   in   1              decoder error; combinational from dec_addr
//  gnt_o        out  GNT_W          current grant index
//  busy         out  1              high when state != IDLE
//  decerr_cnt   out  16             saturating count of locally completed DECERR writes
// BEHAVIOUR
//  Reset:
//   - state=IDLE, rr_ptr=0, gnt=0, awaddr_q=0, m_sel=0, err_q=0, decerr_cnt=0.
//   - While rst=1, every valid/ready output is 0, including combinational ones.
//  Arbitration (IDLE only):
//   - g = first i with s_awvalid[i], scanning rr_ptr, rr_ptr+1, ... mod N.
//   - s_awready[g]=1 that cycle (combinational); capture awaddr_q and gnt; go to DECODE.
//   - All other s_awready are 0.
//  FSM (outputs default 0):
//   - IDLE: arbitration as above.
//   - DECODE: m_sel<=dec_slave_id, err_q<=dec_decerr; go to ERR_W if dec_decerr, else AW.
//   - AW: m_awvalid=1; on m_awready go to W. m_awvalid never drops before the handshake.
//   - W: m_wvalid=s_wvalid[g], s_wready[g]=m_wready; on s_wvalid[g]&m_wready go to B.
//   - B: s_bvalid[g]=m_bvalid, m_bready=s_bready[g], s_bresp=m_bresp.
//     On handshake go to IDLE and set rr_ptr<=(g+1) mod N.
//   - ERR_W: s_wready[g]=1; on s_wvalid[g] drop the data and go to ERR_B.
//   - ERR_B: s_bvalid[g]=1, s_bresp=2'b11.
//     On s_bready[g]: decerr_cnt+=1 (saturates at 16'hFFFF), rr_ptr<=(g+1) mod N, go to IDLE.
//  Latency and ordering:
//   - AW accept to m_awvalid is 2 cycles.
//   - Minimum transaction with zero-wait slave/master is 5 cycles, IDLE to IDLE.
//   - W is forwarded only after the AW handshake.
//   - W presented early by a master waits; s_wready stays 0 until the W state.
//  Boundaries:
//   - Simultaneous requests: only one grant; losers keep s_awvalid asserted.
//   - rr_ptr wraps N-1 -> 0.
//   - Non-granted masters always see s_awready/s_wready/s_bvalid = 0.
//   - rst mid-transaction returns to IDLE next cycle; the in-flight transaction is abandoned
//     and nothing is replayed.
// TESTING
//  (Decoder model: four 4 KB regions at 0x0000/0x1000/0x2000/0x3000; default parameters.)
//  1. Single write: M0 writes 0x1004 data 0xDEADBEEF -> m_sel=1, m_awvalid 2 cycles after AW,
//     m_wdata=0xDEADBEEF, M0 gets BRESP=OKAY.
//  2. Contention: M0 and M1 assert AW in the same cycle after reset -> M0 granted first, then M1.
//     With both continuously requesting, grants alternate 0,1,0,1.
//  3. Unmapped write: M1 writes 0x8000 -> m_awvalid and m_wvalid never assert, M1 gets
//     BRESP=2'b11, decerr_cnt 0->1.
//  4. Backpressure: m_awready low 3 cycles, m_wready low 2, s_bready low 4 -> valids held
//     stable, exactly one handshake per channel, grant held throughout.
//  5. Mid-transaction reset: rst pulsed in state W -> next cycle busy=0, all valid/ready
//     outputs 0, rr_ptr=0.
//  6. Saturation: force decerr_cnt to 16'hFFFE and run 3 DECERR writes -> reads 16'hFFFF.

Source files
------------

// File: rtl/axil_wr_arbiter.sv
// AXI-Lite write-path arbiter: N masters share one downstream write port.
// Round-robin grant on AW, held for the whole AW->W->B sequence. The granted
// address is presented to an external decoder; mapped writes are forwarded
// with the decoded slave id on m_sel, unmapped writes are answered locally
// with DECERR and counted.
module axil_wr_arbiter #(
  parameter int N          = 2,
  parameter int M          = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLAVE_ID_W = (M > 1) ? $clog2(M) : 1,
  parameter int GNT_W      = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N*ADDR_WIDTH-1:0]      s_awaddr,
  input  logic [N-1:0]                 s_awvalid,
  output logic [N-1:0]                 s_awready,
  input  logic [N*DATA_WIDTH-1:0]      s_wdata,
  input  logic [N*(DATA_WIDTH/8)-1:0]  s_wstrb,
  input  logic [N-1:0]                 s_wvalid,
  output logic [N-1:0]                 s_wready,
  output logic [1:0]                   s_bresp,
  output logic [N-1:0]                 s_bvalid,
  input  logic [N-1:0]                 s_bready,
  output logic [ADDR_WIDTH-1:0]        m_awaddr,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic [DATA_WIDTH/8-1:0]      m_wstrb,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic [1:0]                   m_bresp,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  output logic [SLAVE_ID_W-1:0]        m_sel,
  output logic [ADDR_WIDTH-1:0]        dec_addr,
  input  logic [SLAVE_ID_W-1:0]        dec_slave_id,
  input  logic                         dec_decerr,
  output logic [GNT_W-1:0]             gnt_o,
  output logic                         busy,
  output logic [15:0]                  decerr_cnt
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_AW,
    S_W,
    S_B,
    S_ERR_W,
    S_ERR_B
  } state_t;

  state_t                  state;
  logic [GNT_W-1:0]        rr_ptr;
  logic [GNT_W-1:0]        gnt;
  logic [GNT_W-1:0]        gnt_next;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic                    err_q;
  logic [GNT_W-1:0]        cand [N];
  logic [GNT_W-1:0]        pick;
  logic                    pick_found;

  // Candidate master indices in round-robin priority order, starting at rr_ptr
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cand[k] = GNT_W'((int'(rr_ptr) + k) % N);
    end
  end

  // First requesting master in priority order wins
  always_comb begin
    pick_found = 1'b0;
    pick       = rr_ptr;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && s_awvalid[cand[k]]) begin
        pick_found = 1'b1;
        pick       = cand[k];
      end
    end
  end

  // Pointer advances past the master that just completed, wrapping N-1 -> 0
  always_comb begin
    gnt_next = (gnt == GNT_W'(N - 1)) ? '0 : gnt + 1'b1;
  end

  // Per-state handshake steering; everything is held low while in reset
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = 2'b00;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (pick_found) s_awready[pick] = 1'b1;
        end
        S_AW: begin
          m_awvalid = 1'b1;
        end
        S_W: begin
          m_wvalid       = s_wvalid[gnt];
          s_wready[gnt]  = m_wready;
        end
        S_B: begin
          s_bvalid[gnt] = m_bvalid;
          m_bready      = s_bready[gnt];
          s_bresp       = m_bresp;
        end
        S_ERR_W: begin
          s_wready[gnt] = 1'b1;
        end
        S_ERR_B: begin
          s_bvalid[gnt] = 1'b1;
          s_bresp       = 2'b11;
        end
        default: ;
      endcase
    end
  end

  // Write data path follows the held grant
  always_comb begin
    m_wdata = s_wdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
    m_wstrb = s_wstrb[int'(gnt)*STRB_W +: STRB_W];
  end

  assign m_awaddr = awaddr_q;
  assign dec_addr = awaddr_q;
  assign gnt_o    = gnt;
  assign busy     = (state != S_IDLE);

  // Transaction sequencer: arbitrate, decode, then forward or complete locally
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      gnt        <= '0;
      awaddr_q   <= '0;
      m_sel      <= '0;
      err_q      <= 1'b0;
      decerr_cnt <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            gnt      <= pick;
            awaddr_q <= s_awaddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          m_sel <= dec_slave_id;
          err_q <= dec_decerr;
          state <= dec_decerr ? S_ERR_W : S_AW;
        end
        S_AW: begin
          if (m_awready) state <= S_W;
        end
        S_W: begin
          if (s_wvalid[gnt] && m_wready) state <= S_B;
        end
        S_B: begin
          if (m_bvalid && s_bready[gnt]) begin
            rr_ptr <= gnt_next;
            state  <= S_IDLE;
          end
        end
        S_ERR_W: begin
          // Write data of an unmapped access is accepted and discarded
          if (s_wvalid[gnt]) state <= S_ERR_B;
        end
        S_ERR_B: begin
          if (s_bready[gnt]) begin
            if (err_q && (decerr_cnt != 16'hFFFF)) decerr_cnt <= decerr_cnt + 16'h0001;
            rr_ptr <= gnt_next;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Scoreboard bench for axil_wr_arbiter: directed transactions push expected
// forwarded AW/W beats, grant order and B responses into queues; a monitor
// pops and compares them as the handshakes occur.
module tb_axil_wr_arbiter;

  localparam int N    = 2;
  localparam int M    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int SIDW = 2;
  localparam int GW   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N*AW-1:0]     s_awaddr;
  logic [N-1:0]        s_awvalid;
  logic [N-1:0]        s_awready;
  logic [N*DW-1:0]     s_wdata;
  logic [N*SW-1:0]     s_wstrb;
  logic [N-1:0]        s_wvalid;
  logic [N-1:0]        s_wready;
  logic [1:0]          s_bresp;
  logic [N-1:0]        s_bvalid;
  logic [N-1:0]        s_bready;
  logic [AW-1:0]       m_awaddr;
  logic                m_awvalid;
  logic                m_awready;
  logic [DW-1:0]       m_wdata;
  logic [SW-1:0]       m_wstrb;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;
  logic [SIDW-1:0]     m_sel;
  logic [AW-1:0]       dec_addr;
  logic [SIDW-1:0]     dec_slave_id;
  logic                dec_decerr;
  logic [GW-1:0]       gnt_o;
  logic                busy;
  logic [15:0]         decerr_cnt;

  // per-master drive variables
  logic [AW-1:0] awaddr_m  [N];
  logic [DW-1:0] wdata_m   [N];
  logic [SW-1:0] wstrb_m   [N];
  logic          awvalid_m [N];
  logic          wvalid_m  [N];
  logic          bready_m  [N];

  assign s_awaddr  = {awaddr_m[1], awaddr_m[0]};
  assign s_wdata   = {wdata_m[1], wdata_m[0]};
  assign s_wstrb   = {wstrb_m[1], wstrb_m[0]};
  assign s_awvalid = {awvalid_m[1], awvalid_m[0]};
  assign s_wvalid  = {wvalid_m[1], wvalid_m[0]};
  assign s_bready  = {bready_m[1], bready_m[0]};

  // decoder model: four 4 KB regions from 0x0000, everything else unmapped
  assign dec_decerr   = (dec_addr >= 32'h0000_4000);
  assign dec_slave_id = dec_addr[13:12];

  axil_wr_arbiter #(
    .N(N), .M(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_sel(m_sel), .dec_addr(dec_addr), .dec_slave_id(dec_slave_id),
    .dec_decerr(dec_decerr), .gnt_o(gnt_o), .busy(busy), .decerr_cnt(decerr_cnt)
  );

  int tests = 0;
  int fails = 0;

  logic [SIDW+AW-1:0] aw_q [$];
  logic [SW+DW-1:0]   w_q  [$];
  logic [2:0]         b_q  [$];
  int                 gnt_q [$];

  int aw_wait = 0;
  int w_wait  = 0;
  logic [1:0] slave_resp = 2'b00;

  int cyc = 0, accept_cyc = -100;
  int aw_hs = 0, w_hs = 0, b_hs = 0;
  int awv_cycles = 0, wv_cycles = 0;
  int busy_run = 0, last_busy_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // slave model: programmable AW/W stalls, B one cycle after the W beat
  initial begin
    int aw_c, w_c;
    logic b_fire;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    aw_c = 0; w_c = 0; b_fire = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        aw_c = 0; w_c = 0; b_fire = 1'b0;
      end else begin
        if (b_fire) m_bvalid = 1'b0;
        if (m_awready) begin
          m_awready = 1'b0; aw_c = 0;
        end else if (m_awvalid) begin
          if (aw_c >= aw_wait) m_awready = 1'b1; else aw_c++;
        end
        if (m_wready) begin
          m_wready = 1'b0; w_c = 0;
          m_bvalid = 1'b1; m_bresp = slave_resp;
        end else if (m_wvalid) begin
          if (w_c >= w_wait) m_wready = 1'b1; else w_c++;
        end
        #2;
        b_fire = m_bvalid && m_bready;
      end
    end
  end

  // one complete master write; W optionally presented together with AW
  task automatic mwrite(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [SW-1:0] strb, input bit w_early, input int bdelay);
    bit done;
    int seen;
    @(negedge clk);
    awaddr_m[m] = addr; awvalid_m[m] = 1'b1;
    wdata_m[m] = data; wstrb_m[m] = strb;
    if (w_early) wvalid_m[m] = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      #3;
      if (s_awready[m]) done = 1'b1; else @(negedge clk);
    end
    check("aw_accept_in_time", done, 1);
    @(negedge clk);
    awvalid_m[m] = 1'b0; wvalid_m[m] = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      #3;
      if (s_wready[m]) done = 1'b1; else @(negedge clk);
    end
    check("w_accept_in_time", done, 1);
    done = 1'b0; seen = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      wvalid_m[m] = 1'b0;
      if (seen >= bdelay) bready_m[m] = 1'b1;
      #3;
      if (s_bvalid[m]) begin
        if (s_bready[m]) done = 1'b1; else seen++;
      end
    end
    check("b_in_time", done, 1);
    @(negedge clk);
    bready_m[m] = 1'b0;
  endtask

  // monitor: scoreboard pops, latency, stability and isolation checks
  initial begin
    logic prev_awv, prev_awr, prev_wv, prev_wr, prev_busy, aw_done;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic [N-1:0] prev_bv, prev_br;
    logic [1:0] prev_bresp;
    logic [GW-1:0] prev_gnt;
    prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0; prev_busy = 0; aw_done = 0;
    prev_addr = '0; prev_wdata = '0; prev_bv = '0; prev_br = '0; prev_bresp = '0; prev_gnt = '0;
    forever begin
      @(negedge clk); #3;
      cyc++;
      if (rst) begin
        prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0; prev_busy = 0; aw_done = 0;
        prev_bv = '0; prev_br = '0; busy_run = 0;
      end else begin
        if ((s_awvalid & s_awready) != '0) begin
          accept_cyc = cyc;
          check("awready_onehot", $countones(s_awready), 1);
          if (gnt_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL grant_unexpected: actual awready 0x%0h required none", s_awready);
          end else check("grant_order", s_awready[1] ? 1 : 0, gnt_q.pop_front());
        end
        if (m_awvalid && !prev_awv) check("aw_latency", cyc - accept_cyc, 2);
        if (prev_awv && !prev_awr) begin
          check("awvalid_held", m_awvalid, 1);
          check("awaddr_held", m_awaddr, prev_addr);
        end
        if (prev_wv && !prev_wr) begin
          check("wvalid_held", m_wvalid, 1);
          check("wdata_held", m_wdata, prev_wdata);
        end
        for (int i = 0; i < N; i++) begin
          if (prev_bv[i] && !prev_br[i]) begin
            check("bvalid_held", s_bvalid[i], 1);
            check("bresp_held", s_bresp, prev_bresp);
          end
        end
        if (m_awvalid) check("wready_before_aw", s_wready, 0);
        if (m_wvalid) check("w_after_aw", aw_done, 1);
        if (busy) begin
          check("awready_while_busy", s_awready, 0);
          for (int i = 0; i < N; i++) begin
            if (i != int'(gnt_o)) check("nongranted_quiet", {s_wready[i], s_bvalid[i]}, 0);
          end
          if (prev_busy) check("gnt_held", gnt_o, prev_gnt);
        end
        if (m_awvalid && m_awready) begin
          aw_hs++; aw_done = 1'b1;
          if (aw_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL aw_unexpected: actual addr 0x%0h required no forwarded AW", m_awaddr);
          end else check("aw_fwd", {m_sel, m_awaddr}, aw_q.pop_front());
        end
        if (m_wvalid && m_wready) begin
          w_hs++;
          if (w_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL w_unexpected: actual data 0x%0h required no forwarded W", m_wdata);
          end else check("w_fwd", {m_wstrb, m_wdata}, w_q.pop_front());
        end
        for (int i = 0; i < N; i++) begin
          if (s_bvalid[i] && s_bready[i]) begin
            b_hs++;
            if (b_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL b_unexpected: actual master %0d resp %0d required none", i, s_bresp);
            end else check("b_resp", {i[0], s_bresp}, b_q.pop_front());
          end
        end
        if (m_awvalid) awv_cycles++;
        if (m_wvalid) wv_cycles++;
        if (busy) busy_run++;
        else if (prev_busy) begin
          last_busy_run = busy_run; busy_run = 0;
        end
        if (!busy) aw_done = 1'b0;
        prev_awv = m_awvalid; prev_awr = m_awready; prev_addr = m_awaddr;
        prev_wv = m_wvalid; prev_wr = m_wready; prev_wdata = m_wdata;
        prev_bv = s_bvalid; prev_br = s_bready; prev_bresp = s_bresp;
        prev_busy = busy; prev_gnt = gnt_o;
      end
    end
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // directed stimulus
  initial begin
    int snap_aw, snap_w, snap_b, snap_awv, snap_wv;
    bit done;
    for (int i = 0; i < N; i++) begin
      awaddr_m[i] = '0; wdata_m[i] = '0; wstrb_m[i] = '0;
      awvalid_m[i] = 1'b0; wvalid_m[i] = 1'b0; bready_m[i] = 1'b0;
    end
    rst = 1'b1;
    awvalid_m[0] = 1'b1; wvalid_m[0] = 1'b1; bready_m[0] = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("rst_handshakes_low", {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}, 0);
    check("rst_busy", busy, 0);
    check("rst_regs", {gnt_o, m_sel, m_awaddr, decerr_cnt}, 0);
    @(negedge clk);
    awvalid_m[0] = 1'b0; wvalid_m[0] = 1'b0; bready_m[0] = 1'b0;
    rst = 1'b0;

    // single mapped write
    gnt_q.push_back(0);
    aw_q.push_back({2'd1, 32'h0000_1004});
    w_q.push_back({4'hF, 32'hDEAD_BEEF});
    b_q.push_back({1'b0, 2'b00});
    mwrite(0, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("t1_busy_cycles", last_busy_run, 4);

    // contention from reset: 0,1,0,1
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
    aw_q.push_back({2'd0, 32'h0000_0010}); aw_q.push_back({2'd2, 32'h0000_2020});
    aw_q.push_back({2'd3, 32'h0000_3FFC}); aw_q.push_back({2'd1, 32'h0000_1000});
    w_q.push_back({4'hF, 32'h1111_1111}); w_q.push_back({4'h3, 32'h2222_2222});
    w_q.push_back({4'h8, 32'h3333_3333}); w_q.push_back({4'h6, 32'h4444_4444});
    b_q.push_back({1'b0, 2'b00}); b_q.push_back({1'b1, 2'b00});
    b_q.push_back({1'b0, 2'b00}); b_q.push_back({1'b1, 2'b00});
    fork
      begin
        mwrite(0, 32'h0000_0010, 32'h1111_1111, 4'hF, 1'b0, 0);
        mwrite(0, 32'h0000_3FFC, 32'h3333_3333, 4'h8, 1'b0, 0);
      end
      begin
        mwrite(1, 32'h0000_2020, 32'h2222_2222, 4'h3, 1'b0, 0);
        mwrite(1, 32'h0000_1000, 32'h4444_4444, 4'h6, 1'b0, 0);
      end
    join

    // unmapped write completed locally
    check("t3_cnt_before", decerr_cnt, 16'h0000);
    snap_awv = awv_cycles; snap_wv = wv_cycles;
    gnt_q.push_back(1);
    b_q.push_back({1'b1, 2'b11});
    mwrite(1, 32'h0000_8000, 32'hCAFE_F00D, 4'hF, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("t3_no_m_awvalid", awv_cycles - snap_awv, 0);
    check("t3_no_m_wvalid", wv_cycles - snap_wv, 0);
    check("t3_cnt_after", decerr_cnt, 16'h0001);

    // backpressure on every channel, second master waiting
    aw_wait = 3; w_wait = 2; slave_resp = 2'b01;
    snap_aw = aw_hs; snap_w = w_hs; snap_b = b_hs;
    gnt_q.push_back(0); gnt_q.push_back(1);
    aw_q.push_back({2'd2, 32'h0000_2100}); aw_q.push_back({2'd0, 32'h0000_0300});
    w_q.push_back({4'h5, 32'hA5A5_A5A5}); w_q.push_back({4'hC, 32'h5A5A_5A5A});
    b_q.push_back({1'b0, 2'b01}); b_q.push_back({1'b1, 2'b01});
    fork
      mwrite(0, 32'h0000_2100, 32'hA5A5_A5A5, 4'h5, 1'b1, 4);
      mwrite(1, 32'h0000_0300, 32'h5A5A_5A5A, 4'hC, 1'b0, 4);
    join
    check("t4_aw_handshakes", aw_hs - snap_aw, 2);
    check("t4_w_handshakes", w_hs - snap_w, 2);
    check("t4_b_handshakes", b_hs - snap_b, 2);
    aw_wait = 0; w_wait = 0; slave_resp = 2'b00;

    // leave rr_ptr at 1, then reset in the middle of a W phase
    gnt_q.push_back(0);
    aw_q.push_back({2'd0, 32'h0000_0004});
    w_q.push_back({4'hF, 32'h0BAD_F00D});
    b_q.push_back({1'b0, 2'b00});
    mwrite(0, 32'h0000_0004, 32'h0BAD_F00D, 4'hF, 1'b0, 0);
    w_wait = 1000;
    gnt_q.push_back(1);
    aw_q.push_back({2'd3, 32'h0000_3000});
    @(negedge clk);
    awaddr_m[1] = 32'h0000_3000; awvalid_m[1] = 1'b1;
    wdata_m[1] = 32'h1234_5678; wstrb_m[1] = 4'hF; wvalid_m[1] = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      #3;
      if (s_awready[1]) done = 1'b1; else @(negedge clk);
    end
    check("t5_aw_accept", done, 1);
    @(negedge clk);
    awvalid_m[1] = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk); #3;
      if (m_wvalid) done = 1'b1;
    end
    check("t5_reached_w", done, 1);
    check("t5_gnt_before", gnt_o, 1);
    @(negedge clk);
    rst = 1'b1;
    #3;
    check("t5_rst_comb_low", {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}, 0);
    @(posedge clk); #1;
    check("t5_busy_after", busy, 0);
    check("t5_outputs_low", {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}, 0);
    check("t5_rr_ptr", dut.rr_ptr, 0);
    check("t5_gnt_after", gnt_o, 0);
    @(negedge clk);
    wvalid_m[1] = 1'b0; w_wait = 0;
    rst = 1'b0;
    snap_awv = awv_cycles;
    repeat (5) @(negedge clk);
    #3;
    check("t5_no_replay_busy", busy, 0);
    check("t5_no_replay_aw", awv_cycles - snap_awv, 0);

    // counter saturation
    @(negedge clk);
    force dut.decerr_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.decerr_cnt;
    #3;
    check("t6_preset", decerr_cnt, 16'hFFFE);
    for (int j = 0; j < 3; j++) begin
      gnt_q.push_back(0);
      b_q.push_back({1'b0, 2'b11});
      mwrite(0, 32'h0000_9000 + 32'(j * 4), 32'h0000_0100 + 32'(j), 4'hF, 1'b0, 0);
      check("t6_saturated", decerr_cnt, 16'hFFFF);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", aw_q.size() + w_q.size() + b_q.size() + gnt_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
